bcd_countdown_core: RTL and testbench

Parametrised BCD cook-timer core: the successor to the fixed four-digit mm:ss time counter. Holds a seconds/tens-of-seconds pair plus a configurable number of minute digits, counts down (or up to a target) on an external 1 s tick, and supports pause/resume, clear and a registered done flag with a one-cycle alarm pulse. Sits between the 1 s clock divider and the display/alarm logic.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/bcd_digit.sv | 49 ++++
 rtl/bcd_countdown_core.sv | 179 +++++++++++++++++
 tb/tb_bcd_countdown_core.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD cook-timer: FSM states, digit limits and sanitising helpers.
// Digit index 0 is seconds, 1 is tens-of-seconds, 2 and up are minute digits.
package timer_pkg;

    localparam int          DIGIT_W   = 4;
    localparam logic [3:0]  DIGIT_MAX = 4'd9;
    localparam logic [3:0]  TENS_MAX  = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 1) ? TENS_MAX : DIGIT_MAX;
    endfunction

    function automatic logic [3:0] bcd_sat(input logic [3:0] d, input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register wrapping at MAX; clear > load > inc > dec.
// Carry/borrow are combinational so a chain of digits ripples within one cycle.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic       clear,
    input  logic [3:0] load_val,
    output logic [3:0] value,
    output logic       carry,
    output logic       borrow,
    output logic       is_zero,
    output logic       is_max
);

    logic [3:0] value_q, value_d;

    assign value   = value_q;
    assign is_zero = (value_q == 4'd0);
    assign is_max  = (value_q == MAX);
    assign carry   = inc & is_max;
    assign borrow  = dec & is_zero;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = 4'd0;
        end else if (load) begin
            value_d = load_val;
        end else if (inc) begin
            value_d = is_max ? 4'd0 : value_q + 4'd1;
        end else if (dec) begin
            value_d = is_zero ? MAX : value_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/bcd_countdown_core.sv
// BCD mm:ss cook-timer counting down (or up to a target) on a 1 s tick; one-cycle command latency.
// Commands resolve clear > load > stop > start > tick; done holds the count until clear or load.
module bcd_countdown_core
    import timer_pkg::*;
#(
    parameter int MIN_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    up_mode,
    input  logic                    load,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic [3:0]              seconds_prog,
    input  logic [3:0]              tens_seconds_prog,
    input  logic [4*MIN_DIGITS-1:0] minutes_prog,
    output logic [3:0]              seconds,
    output logic [3:0]              tens_seconds,
    output logic [4*MIN_DIGITS-1:0] minutes,
    output logic                    running,
    output logic                    done,
    output logic                    alarm
);

    localparam int NUM = 2 + MIN_DIGITS;
    localparam int W   = DIGIT_W * NUM;

    state_e         state_q, state_d;
    logic           mode_q, mode_d;
    logic [W-1:0]   target_q, target_d;
    logic           alarm_q, alarm_d;

    logic           step_inc, step_dec, cnt_load, cnt_clear;
    logic [W-1:0]   prog_raw, prog_san, cnt_flat, post_flat;
    logic [NUM-1:0] max_v, zero_v;
    logic           all_max, term_now, term_post;
    logic           unused_top;

    assign prog_raw = {minutes_prog, tens_seconds_prog, seconds_prog};

    always_comb begin
        prog_san = '0;
        for (int i = 0; i < NUM; i++) begin
            prog_san[i*4 +: 4] = bcd_sat(prog_raw[i*4 +: 4], digit_max(i));
        end
    end

    for (genvar i = 0; i < NUM; i++) begin : g_dig
        logic       inc, dec, carry, borrow, is_zero, is_max;
        logic [3:0] value;

        if (i == 0) begin : g_lsd
            assign inc = step_inc;
            assign dec = step_dec;
        end else begin : g_chain
            assign inc = g_dig[i-1].carry;
            assign dec = g_dig[i-1].borrow;
        end

        bcd_digit #(.MAX(digit_max(i))) u_digit (
            .clk      (clk),
            .reset    (reset),
            .inc      (inc),
            .dec      (dec),
            .load     (cnt_load),
            .clear    (cnt_clear),
            .load_val (prog_san[i*4 +: 4]),
            .value    (value),
            .carry    (carry),
            .borrow   (borrow),
            .is_zero  (is_zero),
            .is_max   (is_max)
        );

        assign cnt_flat[i*4 +: 4] = value;
        assign max_v[i]           = is_max;
        assign zero_v[i]          = is_zero;
    end

    // Wrap out of the most significant digit never happens: up-count saturates, down-count stops at zero.
    assign unused_top = g_dig[NUM-1].carry | g_dig[NUM-1].borrow;

    // Value the counter would take if this cycle's tick is applied, used for the same-edge terminal test.
    always_comb begin
        logic c;
        c         = 1'b1;
        post_flat = cnt_flat;
        for (int i = 0; i < NUM; i++) begin
            if (c) begin
                if (mode_q) begin
                    post_flat[i*4 +: 4] = max_v[i] ? 4'd0 : cnt_flat[i*4 +: 4] + 4'd1;
                    c = max_v[i];
                end else begin
                    post_flat[i*4 +: 4] = zero_v[i] ? digit_max(i) : cnt_flat[i*4 +: 4] - 4'd1;
                    c = zero_v[i];
                end
            end
        end
    end

    assign all_max   = &max_v;
    assign term_now  = mode_q ? (cnt_flat == target_q) : (&zero_v);
    assign term_post = mode_q ? (post_flat == target_q) : (post_flat == '0);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        target_d  = target_q;
        alarm_d   = 1'b0;
        step_inc  = 1'b0;
        step_dec  = 1'b0;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        if (clear) begin
            cnt_clear = 1'b1;
            target_d  = '0;
            state_d   = ST_IDLE;
        end else if (load) begin
            mode_d  = up_mode;
            state_d = ST_IDLE;
            if (up_mode) begin
                cnt_clear = 1'b1;
                target_d  = prog_san;
            end else begin
                cnt_load = 1'b1;
                target_d = '0;
            end
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end
        end else if (start) begin
            if (state_q == ST_IDLE || state_q == ST_PAUSED) begin
                if (term_now) begin
                    state_d = ST_DONE;
                    alarm_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
        end else if (tick && state_q == ST_RUN) begin
            if (mode_q && all_max) begin
                state_d = ST_DONE;
                alarm_d = 1'b1;
            end else begin
                step_inc = mode_q;
                step_dec = ~mode_q;
                if (term_post) begin
                    state_d = ST_DONE;
                    alarm_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            target_q <= '0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            alarm_q  <= alarm_d;
        end
    end

    assign seconds      = cnt_flat[3:0];
    assign tens_seconds = cnt_flat[7:4];
    assign minutes      = cnt_flat[W-1:8];
    assign running      = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign alarm        = alarm_q;

endmodule

// File: tb/tb_bcd_countdown_core.sv
// Directed bench for bcd_countdown_core; the reference model keeps the count as a plain number of seconds.
module tb_bcd_countdown_core;

    localparam int MD   = 2;
    localparam int MAXS = (100 - 1) * 60 + 59;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            tick = 1'b0, up_mode = 1'b0, load = 1'b0;
    logic            start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [3:0]      seconds_prog = '0, tens_seconds_prog = '0;
    logic [4*MD-1:0] minutes_prog = '0;
    logic [3:0]      seconds, tens_seconds;
    logic [4*MD-1:0] minutes;
    logic            running, done, alarm;

    bcd_countdown_core #(.MIN_DIGITS(MD)) dut (
        .clk               (clk),
        .reset             (reset),
        .tick              (tick),
        .up_mode           (up_mode),
        .load              (load),
        .start             (start),
        .stop              (stop),
        .clear             (clear),
        .seconds_prog      (seconds_prog),
        .tens_seconds_prog (tens_seconds_prog),
        .minutes_prog      (minutes_prog),
        .seconds           (seconds),
        .tens_seconds      (tens_seconds),
        .minutes           (minutes),
        .running           (running),
        .done              (done),
        .alarm             (alarm)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state: 0 idle, 1 run, 2 paused, 3 done.
    int m_cnt, m_tgt, m_st;
    bit m_up, m_alarm;

    function automatic int sat(input logic [3:0] d, input int mx);
        return (int'(d) > mx) ? mx : int'(d);
    endfunction

    function automatic int prog_secs();
        int m, p;
        m = 0;
        p = 1;
        for (int i = 0; i < MD; i++) begin
            m += sat(minutes_prog[i*4 +: 4], 9) * p;
            p *= 10;
        end
        return m * 60 + sat(tens_seconds_prog, 5) * 10 + sat(seconds_prog, 9);
    endfunction

    function automatic logic [4*MD-1:0] exp_min(input int c);
        logic [4*MD-1:0] r;
        int mins, p;
        r    = '0;
        mins = c / 60;
        p    = 1;
        for (int i = 0; i < MD; i++) begin
            r[i*4 +: 4] = 4'((mins / p) % 10);
            p *= 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_tgt = 0; m_st = 0; m_up = 1'b0; m_alarm = 1'b0;
    endtask

    task automatic model_update();
        bit term;
        if (!reset) begin
            model_reset();
            return;
        end
        m_alarm = 1'b0;
        if (clear) begin
            m_cnt = 0; m_tgt = 0; m_st = 0;
        end else if (load) begin
            m_up = up_mode;
            if (up_mode) begin m_cnt = 0; m_tgt = prog_secs(); end
            else         begin m_cnt = prog_secs(); m_tgt = 0; end
            m_st = 0;
        end else if (stop) begin
            if (m_st == 1) m_st = 2;
        end else if (start) begin
            if (m_st == 0 || m_st == 2) begin
                term = m_up ? (m_cnt == m_tgt) : (m_cnt == 0);
                if (term) begin m_st = 3; m_alarm = 1'b1; end
                else m_st = 1;
            end
        end else if (tick && m_st == 1) begin
            if (m_up) begin
                if (m_cnt == MAXS) begin m_st = 3; m_alarm = 1'b1; end
                else begin
                    m_cnt++;
                    if (m_cnt == m_tgt) begin m_st = 3; m_alarm = 1'b1; end
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin m_st = 3; m_alarm = 1'b1; end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (seconds !== 4'(m_cnt % 10) || tens_seconds !== 4'((m_cnt % 60) / 10) ||
                minutes !== exp_min(m_cnt) || running !== (m_st == 1) ||
                done !== (m_st == 3) || alarm !== m_alarm) begin
                n_err++;
                $display("FAIL cycle_compare t=%0t got %h:%h%h run=%b done=%b alarm=%b want %h:%0d%0d run=%b done=%b alarm=%b",
                         $time, minutes, tens_seconds, seconds, running, done, alarm,
                         exp_min(m_cnt), (m_cnt % 60) / 10, m_cnt % 10, (m_st == 1), (m_st == 3), m_alarm);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic do_load(input bit um, input logic [7:0] m, input logic [3:0] t, input logic [3:0] s);
        up_mode = um; minutes_prog = m; tens_seconds_prog = t; seconds_prog = s;
        load = 1'b1; cyc(); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    task automatic do_tick(input int n);
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
    endtask

    function automatic logic [15:0] mmss();
        return {minutes, tens_seconds, seconds};
    endfunction

    initial begin
        model_reset();
        repeat (2) cyc();
        chk_en = 1'b1;
        chk("reset_digits", {16'h0, mmss()}, 32'h0);
        chk("reset_flags", {running, done, alarm}, 3'b000);
        reset = 1'b1;
        cyc();

        // Countdown 00:03 to done
        do_load(1'b0, 8'h00, 4'd0, 4'd3);
        do_start();
        do_tick(1);
        chk("down_first_tick", {16'h0, mmss()}, 32'h0002);
        cyc();
        do_tick(1);
        cyc();
        do_tick(1);
        chk("down_done", {running, done, alarm}, 3'b011);
        chk("down_zero", {16'h0, mmss()}, 32'h0000);
        cyc();
        chk("alarm_one_cycle", {done, alarm}, 2'b10);
        do_tick(3);
        chk("done_holds", {16'h0, mmss()}, 32'h0000);

        // Borrow chains
        do_load(1'b0, 8'h10, 4'd0, 4'd0);
        do_start();
        do_tick(1);
        chk("borrow_10_00", {16'h0, mmss()}, 32'h0959);
        do_load(1'b0, 8'h01, 4'd0, 4'd0);
        do_start();
        do_tick(1);
        chk("borrow_01_00", {16'h0, mmss()}, 32'h0059);

        // Pause / resume and same-cycle command priority
        do_load(1'b0, 8'h12, 4'd3, 4'd4);
        do_start();
        do_stop();
        do_tick(5);
        chk("paused_hold", {15'h0, running, mmss()}, 32'h1234);
        do_start();
        do_tick(1);
        chk("resume_tick", {16'h0, mmss()}, 32'h1233);
        stop = 1'b1; tick = 1'b1; cyc(); stop = 1'b0; tick = 1'b0;
        chk("stop_beats_tick", {15'h0, running, mmss()}, 32'h1233);
        start = 1'b1; tick = 1'b1; cyc(); start = 1'b0; tick = 1'b0;
        chk("start_beats_tick", {15'h0, running, mmss()}, 32'h11233);
        do_tick(1);

        // Sanitising and immediate done
        do_load(1'b0, 8'h00, 4'd7, 4'd12);
        chk("sanitise", {16'h0, mmss()}, 32'h0059);
        do_load(1'b0, 8'h00, 4'd0, 4'd0);
        do_start();
        chk("immediate_done", {done, alarm}, 2'b11);
        cyc();
        chk("immediate_alarm_drop", {done, alarm}, 2'b10);

        // load+start: load wins
        up_mode = 1'b0; minutes_prog = 8'h00; tens_seconds_prog = 4'd2; seconds_prog = 4'd0;
        load = 1'b1; start = 1'b1; cyc(); load = 1'b0; start = 1'b0;
        chk("load_beats_start", {15'h0, running, mmss()}, 32'h0020);

        // Up mode
        do_load(1'b1, 8'h01, 4'd0, 4'd5);
        chk("up_load_zero", {16'h0, mmss()}, 32'h0000);
        do_start();
        do_tick(64);
        chk("up_64", {15'h0, running, mmss()}, 32'h10104);
        do_tick(1);
        chk("up_target", {14'h0, running, done, mmss()}, 32'h10105);
        do_load(1'b1, 8'h99, 4'd5, 4'd9);
        do_start();
        do_tick(MAXS - 1);
        chk("up_9958", {15'h0, running, mmss()}, 32'h19958);
        do_tick(1);
        chk("up_9959_done", {14'h0, done, alarm, mmss()}, 32'h39959);
        do_tick(4);
        chk("up_saturate_hold", {15'h0, done, mmss()}, 32'h19959);

        // clear+load: clear wins
        up_mode = 1'b0; minutes_prog = 8'h05; tens_seconds_prog = 4'd0; seconds_prog = 4'd0;
        clear = 1'b1; load = 1'b1; cyc(); clear = 1'b0; load = 1'b0;
        chk("clear_beats_load", {14'h0, running, done, mmss()}, 32'h0);

        // Asynchronous reset mid-run
        do_load(1'b0, 8'h00, 4'd0, 4'd5);
        do_start();
        do_tick(1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_reset", {13'h0, running, done, alarm, mmss()}, 32'h0);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        do_tick(2);
        chk("idle_after_reset", {14'h0, running, done, mmss()}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
